tnoc_input_vc_buffer: RTL and testbench

Per-virtual-channel input stage of a router port, sitting directly upstream of the output block's switch and port controllers. It buffers incoming flits in a FIFO and computes the XY route from each head flit. It then requests the selected output port and waits for the grant. Once granted, it streams the packet through to its tail flit and signals port release. One instance exists per input port per virtual channel.

---
 rtl/tnoc_input_vc_buffer.sv | 194 +++++++++++++++++++
 tb/tb_tnoc_input_vc_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tnoc_input_vc_buffer.sv
// Purpose: per-VC input stage. Buffers flits, XY-routes each head flit, then requests an output port and streams the packet once granted.
// Latency: head pushed in cycle 0 raises o_request in cycle 2; grant in cycle n lets the first flit leave in cycle n+1.
// Backpressure: o_flit_ready = !full from the registered count only. Downstream stalls by holding i_flit_ready low.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   i_flit_valid/o_flit_ready upstream flit handshake, i_flit carries the flit
//   o_vc_available            at least two free entries (occupancy <= DEPTH-2)
//   o_request/i_grant         one-hot port request/grant {y-, y+, x-, x+, local}
//   o_free                    tail-flit handshake pulse, releases the granted port
//   o_flit_valid/i_flit_ready downstream flit handshake, o_flit is the FIFO head
//   o_error                   pulse when an orphan (non-head) flit is dropped while idle
module tnoc_input_vc_buffer #(
    parameter int FLIT_WIDTH = 64,
    parameter int X_WIDTH    = 3,
    parameter int Y_WIDTH    = 3,
    parameter int X_ID       = 0,
    parameter int Y_ID       = 0,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flit_valid,
    output logic                  o_flit_ready,
    input  logic [FLIT_WIDTH-1:0] i_flit,
    output logic                  o_vc_available,
    output logic [4:0]            o_request,
    input  logic [4:0]            i_grant,
    output logic                  o_free,
    output logic                  o_flit_valid,
    input  logic                  i_flit_ready,
    output logic [FLIT_WIDTH-1:0] o_flit,
    output logic                  o_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [X_WIDTH-1:0] MY_X = X_WIDTH'(X_ID);
    localparam logic [Y_WIDTH-1:0] MY_Y = Y_WIDTH'(Y_ID);

    localparam logic [4:0] PORT_LOCAL = 5'b00001;
    localparam logic [4:0] PORT_XP    = 5'b00010;
    localparam logic [4:0] PORT_XM    = 5'b00100;
    localparam logic [4:0] PORT_YP    = 5'b01000;
    localparam logic [4:0] PORT_YM    = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_t;

    logic [FLIT_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    state_t                state_q;
    logic [4:0]            route_q;
    logic [4:0]            request_q;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  out_hs;
    logic                  drop;
    logic [FLIT_WIDTH-1:0] head_flit;
    logic                  is_head;
    logic                  is_tail;
    logic [X_WIDTH-1:0]    dest_x;
    logic [Y_WIDTH-1:0]    dest_y;
    logic [4:0]            route_calc;

    // ---------------- FIFO status and handshakes ----------------
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign head_flit = mem_q[rd_ptr_q];
    assign is_head   = head_flit[FLIT_WIDTH-1];
    assign is_tail   = head_flit[FLIT_WIDTH-2];

    // Ready and availability come from the registered count only, so there
    // is no combinational path from downstream ready back to upstream.
    assign o_flit_ready   = !full;
    assign o_vc_available = (count_q <= CNT_W'(DEPTH - 2));

    assign o_flit_valid = (state_q == ST_ACTIVE) && !empty;
    assign out_hs       = o_flit_valid && i_flit_ready;
    // A non-head flit at the head while idle has no packet context: discard it.
    assign drop         = (state_q == ST_IDLE) && !empty && !is_head;

    assign push = i_flit_valid && !full;
    assign pop  = out_hs || drop;

    assign o_free    = out_hs && is_tail;
    assign o_error   = drop;
    assign o_flit    = head_flit;
    assign o_request = request_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so o_flit reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= i_flit;
        end
    end

    // ---------------- XY route from the FIFO head ----------------
    assign dest_x = head_flit[X_WIDTH-1:0];
    assign dest_y = head_flit[X_WIDTH+Y_WIDTH-1:X_WIDTH];

    always_comb begin
        route_calc = PORT_LOCAL;
        if (dest_x > MY_X) begin
            route_calc = PORT_XP;
        end else if (dest_x < MY_X) begin
            route_calc = PORT_XM;
        end else if (dest_y > MY_Y) begin
            route_calc = PORT_YP;
        end else if (dest_y < MY_Y) begin
            route_calc = PORT_YM;
        end
    end

    // ---------------- Packet FSM ----------------
    // request_q is loaded together with the route and held through ACTIVE so
    // the port controller keeps its grant until the tail has gone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            route_q   <= '0;
            request_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty && is_head) begin
                        route_q   <= route_calc;
                        request_q <= route_calc;
                        state_q   <= ST_REQUEST;
                    end
                end
                ST_REQUEST: begin
                    if ((i_grant & route_q) != 5'b0) begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (o_free) begin
                        request_q <= '0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    request_q <= '0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tnoc_input_vc_buffer.sv
module tb_tnoc_input_vc_buffer;

    localparam int FW    = 64;
    localparam int DEPTH = 4;
    localparam int MY_X  = 1;
    localparam int MY_Y  = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_flit_valid;
    logic          o_flit_ready;
    logic [FW-1:0] i_flit;
    logic          o_vc_available;
    logic [4:0]    o_request;
    logic [4:0]    i_grant;
    logic          o_free;
    logic          o_flit_valid;
    logic          i_flit_ready;
    logic [FW-1:0] o_flit;
    logic          o_error;

    always #5 clk = ~clk;

    tnoc_input_vc_buffer #(
        .FLIT_WIDTH (FW),
        .X_WIDTH    (3),
        .Y_WIDTH    (3),
        .X_ID       (MY_X),
        .Y_ID       (MY_Y),
        .DEPTH      (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_flit_valid   (i_flit_valid),
        .o_flit_ready   (o_flit_ready),
        .i_flit         (i_flit),
        .o_vc_available (o_vc_available),
        .o_request      (o_request),
        .i_grant        (i_grant),
        .o_free         (o_free),
        .o_flit_valid   (o_flit_valid),
        .i_flit_ready   (i_flit_ready),
        .o_flit         (o_flit),
        .o_error        (o_error)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: packet-level view of the buffer.
    // phase 0 = waiting for a head, 1 = waiting for grant, 2 = streaming.
    logic [FW-1:0] mq [$];
    int            phase = 0;
    logic [4:0]    mroute = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] xy_route(input int dx, input int dy);
        if (dx > MY_X) return 5'b00010;
        if (dx < MY_X) return 5'b00100;
        if (dy > MY_Y) return 5'b01000;
        if (dy < MY_Y) return 5'b10000;
        return 5'b00001;
    endfunction

    function automatic logic [FW-1:0] mk(input logic h, input logic t, input logic [2:0] x, input logic [2:0] y);
        logic [23:0] hi;
        logic [31:0] lo;
        hi = 24'($urandom);
        lo = $urandom;
        return {h, t, hi, lo, y, x};
    endfunction

    // One clock cycle: drive inputs, compare all outputs against the model,
    // then advance the model to what the next clock edge must produce.
    task automatic cycle(input logic v, input logic [FW-1:0] f, input logic [4:0] g, input logic r);
        logic e_rdy, e_vld, hs, e_free, e_err, do_push;
        @(posedge clk);
        #1;
        i_flit_valid = v;
        i_flit       = f;
        i_grant      = g;
        i_flit_ready = r;
        #3;
        e_rdy  = (mq.size() < DEPTH);
        e_vld  = (phase == 2) && (mq.size() > 0);
        hs     = e_vld && r;
        e_free = hs && mq[0][FW-2];
        e_err  = (phase == 0) && (mq.size() > 0) && !mq[0][FW-1];
        check("flit_ready", o_flit_ready, e_rdy);
        check("vc_available", o_vc_available, mq.size() <= DEPTH - 2);
        check("request", o_request, (phase != 0) ? mroute : 5'b0);
        check("flit_valid", o_flit_valid, e_vld);
        check("free", o_free, e_free);
        check("error", o_error, e_err);
        if (e_vld) check("flit_data", o_flit, mq[0]);
        do_push = v && e_rdy;
        case (phase)
            0: if (mq.size() > 0 && mq[0][FW-1]) begin
                   mroute = xy_route(int'(mq[0][2:0]), int'(mq[0][5:3]));
                   phase  = 1;
               end
            1: if ((g & mroute) != 5'b0) phase = 2;
            default: if (e_free) phase = 0;
        endcase
        if (hs || e_err) void'(mq.pop_front());
        if (do_push) mq.push_back(f);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst          = 1'b1;
        i_flit_valid = 1'b0;
        i_flit       = '0;
        i_grant      = '0;
        i_flit_ready = 1'b0;
        #1;
        check("rst_flit_ready", o_flit_ready, 1);
        check("rst_vc_available", o_vc_available, 1);
        check("rst_request", o_request, 0);
        check("rst_free", o_free, 0);
        check("rst_flit_valid", o_flit_valid, 0);
        check("rst_error", o_error, 0);
        check("rst_flit", o_flit, 0);
        mq.delete();
        phase  = 0;
        mroute = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Single-flit packet: request two cycles after the push, flit and free
    // together in the cycle after the grant.
    task automatic single_pkt(input logic [2:0] x, input logic [2:0] y, input logic [4:0] exp_route);
        cycle(1, mk(1, 1, x, y), 5'b0, 0);
        cycle(0, '0, 5'b0, 0);
        cycle(0, '0, exp_route, 0);
        check("pkt_route", o_request, exp_route);
        cycle(0, '0, 5'b0, 1);
        check("pkt_out_valid", o_flit_valid, 1);
        check("pkt_out_free", o_free, 1);
        cycle(0, '0, 5'b0, 1);
        check("pkt_req_cleared", o_request, 0);
    endtask

    initial begin
        rst          = 1'b1;
        i_flit_valid = 1'b0;
        i_flit       = '0;
        i_grant      = '0;
        i_flit_ready = 1'b0;
        do_reset();

        // Local and XY priority cases
        single_pkt(3'd1, 3'd1, 5'b00001);
        single_pkt(3'd3, 3'd0, 5'b00010);
        single_pkt(3'd0, 3'd3, 5'b00100);
        single_pkt(3'd1, 3'd3, 5'b01000);
        single_pkt(3'd1, 3'd0, 5'b10000);

        // Grant on a non-matching port is ignored
        cycle(1, mk(1, 0, 3'd3, 3'd0), 5'b0, 0);
        cycle(1, mk(0, 1, 3'd0, 3'd0), 5'b0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, '0, 5'b01000, 0);
            check("mismatch_valid", o_flit_valid, 0);
            check("mismatch_req", o_request, 5'b00010);
        end
        cycle(0, '0, 5'b00010, 0);
        cycle(0, '0, 5'b0, 0);
        check("match_active", o_flit_valid, 1);
        cycle(0, '0, 5'b0, 1);
        cycle(0, '0, 5'b0, 1);
        check("mismatch_tail_free", o_free, 1);

        // Fill to full under backpressure, then drain across the pointer wrap
        cycle(1, mk(1, 0, 3'd3, 3'd0), 5'b0, 0);
        cycle(1, mk(0, 0, 3'd5, 3'd5), 5'b0, 0);
        cycle(1, mk(0, 0, 3'd6, 3'd6), 5'b0, 0);
        check("two_held_avail", o_vc_available, 1);
        cycle(1, mk(0, 1, 3'd7, 3'd7), 5'b0, 0);
        check("three_held_avail", o_vc_available, 0);
        check("three_held_ready", o_flit_ready, 1);
        cycle(1, mk(1, 1, 3'd2, 3'd2), 5'b00010, 0);
        check("full_ready", o_flit_ready, 0);
        for (int i = 0; i < 4; i++) cycle(0, '0, 5'b0, 1);
        check("drain_tail_free", o_free, 1);
        cycle(0, '0, 5'b0, 1);

        // Orphan body flit while idle
        cycle(1, mk(0, 0, 3'd4, 3'd4), 5'b0, 0);
        cycle(0, '0, 5'b0, 0);
        check("orphan_error", o_error, 1);
        check("orphan_no_req", o_request, 0);
        cycle(0, '0, 5'b0, 0);
        check("orphan_error_once", o_error, 0);
        check("orphan_empty", o_vc_available, 1);
        cycle(0, '0, 5'b0, 0);
        check("orphan_still_no_req", o_request, 0);

        // Reset in the middle of an active packet
        cycle(1, mk(1, 0, 3'd3, 3'd0), 5'b0, 0);
        cycle(1, mk(0, 0, 3'd3, 3'd3), 5'b0, 0);
        cycle(0, '0, 5'b00010, 0);
        cycle(0, '0, 5'b0, 0);
        check("pre_rst_active", o_flit_valid, 1);
        do_reset();
        single_pkt(3'd1, 3'd3, 5'b01000);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic       v, r;
            logic [4:0] g;
            v = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 3) != 0);
            g = ($urandom_range(0, 1) != 0) ? 5'(32'd1 << $urandom_range(0, 4)) : 5'b0;
            cycle(v, mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))), g, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
